// File: rtl/tlb_pkg.sv
// tlb_pkg: shared op codes, FSM states and CSR field positions for the
// TLB management initiator (tlb_op_ctrl and its interface).
package tlb_pkg;

    localparam int TLBNUM_DFLT = 32;

    localparam int INV_OP_W = 5;
    localparam int ASID_W   = 10;
    localparam int VPPN_W   = 19;
    localparam int PS_W     = 6;

    // Highest legal INVTLB op; anything above reports INE.
    localparam logic [INV_OP_W-1:0] INV_OP_MAX = 5'd6;

    // TLBIDX / TLBELO field positions.
    localparam int IDX_INDEX_LSB = 0;
    localparam int IDX_PS_LSB    = 24;
    localparam int IDX_NE        = 31;
    localparam int ELO_G         = 6;

    typedef enum logic [2:0] {
        TLBOP_SRCH = 3'd0,
        TLBOP_RD   = 3'd1,
        TLBOP_WR   = 3'd2,
        TLBOP_FILL = 3'd3,
        TLBOP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SRCH  = 3'd1,
        S_RD    = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } tlb_state_e;

    // Unknown op codes and out-of-range INVTLB ops both complete with INE.
    function automatic logic op_is_illegal(
        input logic [2:0]          code,
        input logic [INV_OP_W-1:0] inv_op
    );
        return (code > 3'(TLBOP_INV)) ||
               ((code == 3'(TLBOP_INV)) && (inv_op > INV_OP_MAX));
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: EX-side op request (valid/ready + operands) and the
// done/ine completion pulse. master = pipeline, slave = tlb_op_ctrl.
interface tlb_op_ctrl_if;
    import tlb_pkg::*;

    logic                op_valid;
    logic                op_ready;
    logic [2:0]          op_code;
    logic [INV_OP_W-1:0] inv_op;
    logic [ASID_W-1:0]   inv_asid;
    logic [VPPN_W-1:0]   inv_vpn;
    logic                done_valid;
    logic                done_ine;

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vpn,
        input  op_ready, done_valid, done_ine
    );

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vpn,
        output op_ready, done_valid, done_ine
    );

endinterface

// File: rtl/tlb_rand_idx.sv
// tlb_rand_idx: free-running 0..TLBNUM-1 wrap counter used as TLBFILL
// victim; sample captures the count, rand_index holds the captured value.
module tlb_rand_idx
    import tlb_pkg::*;
#(
    parameter int  TLBNUM = TLBNUM_DFLT,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample,
    output logic [IDX_W-1:0] rand_index
);

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] smp_q, smp_d;

    always_comb begin
        cnt_d = cnt_q + IDX_W'(1);
        // Explicit wrap so non power-of-two TLBNUM stays in range.
        if (cnt_q == IDX_W'(TLBNUM - 1)) begin
            cnt_d = '0;
        end
        smp_d = sample ? cnt_q : smp_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            smp_q <= smp_d;
        end
    end

    assign rand_index = smp_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: runs one TLBSRCH/RD/WR/FILL/INVTLB op on addr_trans.
// Ports: clk/reset, flush, op_if (EX op + done), TLB strobes, r_* read
// port, CSR write-back enables and data.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int  TLBNUM = TLBNUM_DFLT,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    tlb_op_ctrl_if.slave        op_if,
    output logic                tlbsrch_en,
    input  logic                srch_finish,
    input  logic                srch_found,
    input  logic [IDX_W-1:0]    srch_index,
    output logic                tlb_wen,
    output logic                tlb_fill_en,
    output logic [IDX_W-1:0]    rand_index,
    output logic                tlbinv_en,
    output logic [INV_OP_W-1:0] tlbinv_op,
    output logic [ASID_W-1:0]   tlbinv_asid,
    output logic [VPPN_W-1:0]   tlbinv_vpn,
    input  logic [VPPN_W-1:0]   r_vppn,
    input  logic [ASID_W-1:0]   r_asid,
    input  logic                r_g,
    input  logic [PS_W-1:0]     r_ps,
    input  logic                r_e,
    input  logic [31:0]         r_lo0,
    input  logic [31:0]         r_lo1,
    output logic                srch_we,
    output logic                rd_we,
    output logic [31:0]         idx_wdata,
    output logic [31:0]         ehi_wdata,
    output logic [31:0]         elo0_wdata,
    output logic [31:0]         elo1_wdata,
    output logic [ASID_W-1:0]   asid_wdata
);

    tlb_state_e          state_q, state_d;
    logic [2:0]          code_q, code_d;
    logic                ine_q, ine_d;
    logic [INV_OP_W-1:0] inv_op_q, inv_op_d;
    logic [ASID_W-1:0]   inv_asid_q, inv_asid_d;
    logic [VPPN_W-1:0]   inv_vpn_q, inv_vpn_d;

    logic op_ready;
    logic accept;
    logic fill_smp;
    logic done_valid;
    logic done_ine;

    // A flushed cycle never accepts, so ready drops with flush.
    assign op_ready = (state_q == S_IDLE) && !flush;
    assign accept   = op_if.op_valid && op_ready;
    assign fill_smp = accept && (op_if.op_code == 3'(TLBOP_FILL));

    tlb_rand_idx #(
        .TLBNUM (TLBNUM)
    ) u_rand (
        .clk        (clk),
        .reset      (reset),
        .sample     (fill_smp),
        .rand_index (rand_index)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        ine_d       = ine_q;
        inv_op_d    = inv_op_q;
        inv_asid_d  = inv_asid_q;
        inv_vpn_d   = inv_vpn_q;
        tlbsrch_en  = 1'b0;
        tlb_wen     = 1'b0;
        tlb_fill_en = 1'b0;
        tlbinv_en   = 1'b0;
        srch_we     = 1'b0;
        rd_we       = 1'b0;
        done_valid  = 1'b0;
        done_ine    = 1'b0;
        idx_wdata   = '0;
        ehi_wdata   = '0;
        elo0_wdata  = '0;
        elo1_wdata  = '0;
        asid_wdata  = '0;

        // Flush wins over every state and leaves all strobes low.
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        code_d     = op_if.op_code;
                        ine_d      = op_is_illegal(op_if.op_code,
                                                   op_if.inv_op);
                        inv_op_d   = op_if.inv_op;
                        inv_asid_d = op_if.inv_asid;
                        inv_vpn_d  = op_if.inv_vpn;
                        unique case (1'b1)
                            op_if.op_code == 3'(TLBOP_SRCH):
                                state_d = S_SRCH;
                            op_if.op_code == 3'(TLBOP_RD):
                                state_d = S_RD;
                            default:
                                state_d = S_ISSUE;
                        endcase
                    end
                end
                S_SRCH: begin
                    tlbsrch_en = 1'b1;
                    if (srch_finish) begin
                        srch_we = 1'b1;
                        idx_wdata[IDX_INDEX_LSB +: IDX_W] = srch_index;
                        idx_wdata[IDX_NE] = !srch_found;
                        state_d = S_DONE;
                    end
                end
                S_RD: begin
                    rd_we = 1'b1;
                    if (r_e) begin
                        ehi_wdata  = {r_vppn, 13'b0};
                        elo0_wdata = r_lo0;
                        elo1_wdata = r_lo1;
                        elo0_wdata[ELO_G] = r_g;
                        elo1_wdata[ELO_G] = r_g;
                        asid_wdata = r_asid;
                        idx_wdata[IDX_PS_LSB +: PS_W] = r_ps;
                    end else begin
                        idx_wdata[IDX_NE] = 1'b1;
                    end
                    state_d = S_DONE;
                end
                S_ISSUE: begin
                    if (!ine_q) begin
                        unique case (1'b1)
                            code_q == 3'(TLBOP_WR):   tlb_wen     = 1'b1;
                            code_q == 3'(TLBOP_FILL): tlb_fill_en = 1'b1;
                            code_q == 3'(TLBOP_INV):  tlbinv_en   = 1'b1;
                            default: ;
                        endcase
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    done_valid = 1'b1;
                    done_ine   = ine_q;
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            code_q     <= '0;
            ine_q      <= 1'b0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vpn_q  <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            ine_q      <= ine_d;
            inv_op_q   <= inv_op_d;
            inv_asid_q <= inv_asid_d;
            inv_vpn_q  <= inv_vpn_d;
        end
    end

    assign tlbinv_op   = inv_op_q;
    assign tlbinv_asid = inv_asid_q;
    assign tlbinv_vpn  = inv_vpn_q;

    assign op_if.op_ready   = op_ready;
    assign op_if.done_valid = done_valid;
    assign op_if.done_ine   = done_ine;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed stimulus for tlb_op_ctrl with a latency-based
// reference model checked every cycle plus literal spot checks.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    localparam int IDX_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        tlbsrch_en;
    logic        srch_finish;
    logic        srch_found;
    logic [4:0]  srch_index;
    logic        tlb_wen;
    logic        tlb_fill_en;
    logic [4:0]  rand_index;
    logic        tlbinv_en;
    logic [4:0]  tlbinv_op;
    logic [9:0]  tlbinv_asid;
    logic [18:0] tlbinv_vpn;
    logic [18:0] r_vppn;
    logic [9:0]  r_asid;
    logic        r_g;
    logic [5:0]  r_ps;
    logic        r_e;
    logic [31:0] r_lo0;
    logic [31:0] r_lo1;
    logic        srch_we;
    logic        rd_we;
    logic [31:0] idx_wdata;
    logic [31:0] ehi_wdata;
    logic [31:0] elo0_wdata;
    logic [31:0] elo1_wdata;
    logic [9:0]  asid_wdata;

    tlb_op_ctrl_if op_if ();

    tlb_op_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .op_if       (op_if),
        .tlbsrch_en  (tlbsrch_en),
        .srch_finish (srch_finish),
        .srch_found  (srch_found),
        .srch_index  (srch_index),
        .tlb_wen     (tlb_wen),
        .tlb_fill_en (tlb_fill_en),
        .rand_index  (rand_index),
        .tlbinv_en   (tlbinv_en),
        .tlbinv_op   (tlbinv_op),
        .tlbinv_asid (tlbinv_asid),
        .tlbinv_vpn  (tlbinv_vpn),
        .r_vppn      (r_vppn),
        .r_asid      (r_asid),
        .r_g         (r_g),
        .r_ps        (r_ps),
        .r_e         (r_e),
        .r_lo0       (r_lo0),
        .r_lo1       (r_lo1),
        .srch_we     (srch_we),
        .rd_we       (rd_we),
        .idx_wdata   (idx_wdata),
        .ehi_wdata   (ehi_wdata),
        .elo0_wdata  (elo0_wdata),
        .elo1_wdata  (elo1_wdata),
        .asid_wdata  (asid_wdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: an op is "busy" from accept; non-search ops act
    // one cycle after accept and complete the cycle after that; a search
    // acts in the first cycle that sees srch_finish and completes next.
    int         cyc;
    bit         busy;
    logic [2:0] m_code;
    bit         m_ine;
    int         m_phase;
    bit         m_hit;
    logic [4:0] m_rnd;
    logic [4:0] m_iop;
    logic [9:0] m_asid;
    logic [18:0] m_vpn;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            busy   <= 1'b0;
            m_rnd  <= '0;
            m_iop  <= '0;
            m_asid <= '0;
            m_vpn  <= '0;
            m_hit  <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (flush) begin
                busy <= 1'b0;
            end else if (!busy) begin
                if (op_if.op_valid) begin
                    busy    <= 1'b1;
                    m_code  <= op_if.op_code;
                    m_ine   <= (op_if.op_code > 4) ||
                               (op_if.op_code == 4 && op_if.inv_op > 6);
                    m_phase <= 1;
                    m_hit   <= 1'b0;
                    m_iop   <= op_if.inv_op;
                    m_asid  <= op_if.inv_asid;
                    m_vpn   <= op_if.inv_vpn;
                    if (op_if.op_code == 3)
                        m_rnd <= 5'(cyc % 32);
                end
            end else if (m_code == 0) begin
                if (m_hit) busy <= 1'b0;
                else if (srch_finish) m_hit <= 1'b1;
            end else if (m_phase == 2) begin
                busy <= 1'b0;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic e_rdy, e_srch, e_swe, act, e_rd;
        logic e_wen, e_fill, e_inv, e_done;
        logic [31:0] e_idx, e_ehi, e_lo0, e_lo1;
        logic [9:0]  e_asid;
        if (chk_en && !reset) begin
            e_rdy  = !busy && !flush;
            e_srch = busy && m_code == 0 && !m_hit && !flush;
            e_swe  = e_srch && srch_finish;
            act    = busy && m_code != 0 && m_phase == 1 && !flush;
            e_rd   = act && m_code == 1;
            e_wen  = act && !m_ine && m_code == 2;
            e_fill = act && !m_ine && m_code == 3;
            e_inv  = act && !m_ine && m_code == 4;
            e_done = busy && !flush &&
                     ((m_code == 0 && m_hit) ||
                      (m_code != 0 && m_phase == 2));
            chk("op_ready", op_if.op_ready, e_rdy);
            chk("tlbsrch_en", tlbsrch_en, e_srch);
            chk("srch_we", srch_we, e_swe);
            chk("rd_we", rd_we, e_rd);
            chk("tlb_wen", tlb_wen, e_wen);
            chk("tlb_fill_en", tlb_fill_en, e_fill);
            chk("tlbinv_en", tlbinv_en, e_inv);
            chk("done_valid", op_if.done_valid, e_done);
            chk("done_ine", op_if.done_ine, e_done && m_ine);
            chk("rand_index", rand_index, m_rnd);
            if (e_swe) begin
                e_idx = (srch_found ? 32'h0 : 32'h8000_0000) |
                        32'(srch_index);
                chk("srch_idx", idx_wdata, e_idx);
            end
            if (e_rd) begin
                if (r_e) begin
                    e_idx  = 32'(r_ps) << 24;
                    e_ehi  = 32'(r_vppn) << 13;
                    e_lo0  = (r_lo0 & ~32'h40) | (32'(r_g) << 6);
                    e_lo1  = (r_lo1 & ~32'h40) | (32'(r_g) << 6);
                    e_asid = r_asid;
                end else begin
                    e_idx  = 32'h8000_0000;
                    e_ehi  = 0;
                    e_lo0  = 0;
                    e_lo1  = 0;
                    e_asid = 0;
                end
                chk("rd_idx", idx_wdata, e_idx);
                chk("rd_ehi", ehi_wdata, e_ehi);
                chk("rd_elo0", elo0_wdata, e_lo0);
                chk("rd_elo1", elo1_wdata, e_lo1);
                chk("rd_asid", asid_wdata, e_asid);
            end
            if (e_inv) begin
                chk("inv_op", tlbinv_op, m_iop);
                chk("inv_asid", tlbinv_asid, m_asid);
                chk("inv_vpn", tlbinv_vpn, m_vpn);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] code, input logic [4:0] iop,
                         input logic [9:0] asid, input logic [18:0] vpn);
        op_if.op_valid = 1'b1;
        op_if.op_code  = code;
        op_if.inv_op   = iop;
        op_if.inv_asid = asid;
        op_if.inv_vpn  = vpn;
        tick();
        op_if.op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        op_if.op_valid = 1'b0;
        op_if.op_code  = '0;
        op_if.inv_op   = '0;
        op_if.inv_asid = '0;
        op_if.inv_vpn  = '0;
        srch_finish = 1'b0;
        srch_found  = 1'b0;
        srch_index  = '0;
        r_vppn = '0;
        r_asid = '0;
        r_g    = 1'b0;
        r_ps   = '0;
        r_e    = 1'b0;
        r_lo0  = '0;
        r_lo1  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", op_if.op_ready, 1);
        chk("rst_srch", tlbsrch_en, 0);
        chk("rst_done", op_if.done_valid, 0);
        chk("rst_rnd", rand_index, 0);
        chk("rst_idx", idx_wdata, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // SRCH, finish one cycle after tlbsrch_en
        issue(3'd0, 5'd0, 10'd0, 19'd0);
        @(negedge clk);
        chk("srch_wait_en", tlbsrch_en, 1);
        tick();
        srch_finish = 1'b1;
        srch_found  = 1'b1;
        srch_index  = 5'd5;
        @(negedge clk);
        chk("srch_we_lit", srch_we, 1);
        chk("srch_idx_lit", idx_wdata, 32'h0000_0005);
        tick();
        srch_finish = 1'b0;
        @(negedge clk);
        chk("srch_done_lit", op_if.done_valid, 1);
        tick();

        // SRCH miss, finish in the first cycle
        issue(3'd0, 5'd0, 10'd0, 19'd0);
        srch_finish = 1'b1;
        srch_found  = 1'b0;
        srch_index  = 5'd17;
        @(negedge clk);
        chk("srch_miss_lit", idx_wdata, 32'h8000_0011);
        tick();
        srch_finish = 1'b0;
        tick();

        // RD of an invalid entry
        r_e    = 1'b0;
        r_g    = 1'b0;
        r_vppn = 19'h7_0F0F;
        r_lo0  = 32'hFFFF_FFFF;
        r_lo1  = 32'h1234_5678;
        r_asid = 10'h3FF;
        r_ps   = 6'd21;
        issue(3'd1, 5'd0, 10'd0, 19'd0);
        @(negedge clk);
        chk("rd0_we_lit", rd_we, 1);
        chk("rd0_idx_lit", idx_wdata, 32'h8000_0000);
        chk("rd0_ehi_lit", ehi_wdata, 0);
        chk("rd0_elo_lit", elo0_wdata | elo1_wdata, 0);
        chk("rd0_asid_lit", asid_wdata, 0);
        tick();
        tick();

        // RD of a valid entry
        r_e    = 1'b1;
        r_g    = 1'b1;
        r_vppn = 19'h1234;
        r_ps   = 6'd12;
        r_lo0  = 32'h0ABC_DE15;
        r_lo1  = 32'h0000_0F4F;
        r_asid = 10'h155;
        issue(3'd1, 5'd0, 10'd0, 19'd0);
        @(negedge clk);
        chk("rd1_ehi_lit", ehi_wdata, 32'h0246_8000);
        chk("rd1_idx_lit", idx_wdata, 32'h0C00_0000);
        chk("rd1_elo0_lit", elo0_wdata, 32'h0ABC_DE55);
        chk("rd1_elo1_lit", elo1_wdata, 32'h0000_0F4F);
        chk("rd1_asid_lit", asid_wdata, 10'h155);
        tick();
        tick();

        // a few more RD patterns checked by the model only
        for (int i = 0; i < 4; i++) begin
            r_e    = 1'(i != 2);
            r_g    = 1'(i & 1);
            r_vppn = 19'($urandom);
            r_ps   = 6'($urandom);
            r_lo0  = $urandom | 32'h40;
            r_lo1  = $urandom & ~32'h40;
            r_asid = 10'($urandom);
            issue(3'd1, 5'd0, 10'd0, 19'd0);
            tick();
            tick();
        end

        // WR
        issue(3'd2, 5'd0, 10'd0, 19'd0);
        @(negedge clk);
        chk("wr_wen_lit", tlb_wen, 1);
        tick();
        @(negedge clk);
        chk("wr_wen_off_lit", tlb_wen, 0);
        tick();

        // FILL at counter 31, then again after the wrap
        while ((cyc % 32) != 31) tick();
        issue(3'd3, 5'd0, 10'd0, 19'd0);
        @(negedge clk);
        chk("fill_en_lit", tlb_fill_en, 1);
        chk("fill_rnd_lit", rand_index, 31);
        tick();
        tick();
        issue(3'd3, 5'd0, 10'd0, 19'd0);
        @(negedge clk);
        chk("fill_wrap_lit", rand_index, 2);
        tick();
        tick();

        // INV with illegal op
        issue(3'd4, 5'd7, 10'h0AA, 19'h1_1111);
        @(negedge clk);
        chk("inv7_en_lit", tlbinv_en, 0);
        tick();
        @(negedge clk);
        chk("inv7_done_lit", op_if.done_valid, 1);
        chk("inv7_ine_lit", op_if.done_ine, 1);
        tick();

        // illegal op_code
        issue(3'd6, 5'd0, 10'd0, 19'd0);
        tick();
        @(negedge clk);
        chk("op6_ine_lit", op_if.done_ine, 1);
        tick();

        // INV with legal op
        issue(3'd4, 5'd5, 10'h2A5, 19'h5_1234);
        @(negedge clk);
        chk("inv5_en_lit", tlbinv_en, 1);
        chk("inv5_asid_lit", tlbinv_asid, 10'h2A5);
        chk("inv5_vpn_lit", tlbinv_vpn, 19'h5_1234);
        tick();
        @(negedge clk);
        chk("inv5_en_off_lit", tlbinv_en, 0);
        chk("inv5_ine_lit", op_if.done_ine, 0);
        tick();

        // flush during search wait, racing a finish
        issue(3'd0, 5'd0, 10'd0, 19'd0);
        tick();
        flush       = 1'b1;
        srch_finish = 1'b1;
        srch_found  = 1'b1;
        @(negedge clk);
        chk("fl_srch_en_lit", tlbsrch_en, 0);
        chk("fl_srch_we_lit", srch_we, 0);
        tick();
        flush       = 1'b0;
        srch_finish = 1'b0;
        @(negedge clk);
        chk("fl_ready_lit", op_if.op_ready, 1);
        chk("fl_srch_off_lit", tlbsrch_en, 0);
        repeat (3) tick();

        // op_valid together with flush in IDLE is dropped
        op_if.op_valid = 1'b1;
        op_if.op_code  = 3'd1;
        flush          = 1'b1;
        tick();
        op_if.op_valid = 1'b0;
        flush          = 1'b0;
        @(negedge clk);
        chk("fl_idle_rd_lit", rd_we, 0);
        repeat (2) tick();

        // flush on the WR issue cycle
        issue(3'd2, 5'd0, 10'd0, 19'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_wr_lit", tlb_wen, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_wr_done_lit", op_if.done_valid, 0);
        tick();

        // async reset in the middle of a search
        issue(3'd0, 5'd0, 10'd0, 19'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_srch_lit", tlbsrch_en, 0);
        chk("arst_ready_lit", op_if.op_ready, 1);
        chk("arst_rnd_lit", rand_index, 0);
        tick();
        reset = 1'b0;

        // recovery after reset
        r_e = 1'b1;
        issue(3'd1, 5'd0, 10'd0, 19'd0);
        tick();
        tick();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
